// File: rtl/lut_interp_pkg.sv
// Shared parameters, index-split helpers and swap FSM states for lut_interp_ctrl.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lut_interp_pkg;
  localparam int DWIDTH = 16;            // table entry / output sample width
  localparam int TAW    = 9;             // table index width
  localparam int FW     = 7;             // fractional index width
  localparam int IW     = TAW + FW;      // input sample width
  localparam int AW     = TAW + 1;       // RAM address width, MSB = bank
  localparam int PW     = DWIDTH + FW + 1; // product width

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } swap_state_e;

  function automatic logic [TAW-1:0] idx_of(input logic [IW-1:0] d);
    return d[IW-1:FW];
  endfunction

  function automatic logic [FW-1:0] frac_of(input logic [IW-1:0] d);
    return d[FW-1:0];
  endfunction
endpackage

// File: rtl/lut_interp_ctrl_if.sv
// Sample stream bundle: index samples in, interpolated samples out.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both directions.
interface lut_interp_ctrl_if;
  import lut_interp_pkg::*;

  logic [IW-1:0]     i_tdata;
  logic              i_tlast;
  logic              i_tvalid;
  logic              i_tready;
  logic [DWIDTH-1:0] o_tdata;
  logic              o_tlast;
  logic              o_tvalid;
  logic              o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/lut_interp_math.sv
// Interpolation datapath: capture frac/last, diff*frac, then a + (prod >>> FW).
// Latency: 3 clocks from accept edge to o_vld.
// Backpressure: every stage holds while i_en = 0.
// Ports: i_en pipeline enable, i_vld/i_frac/i_last from the accept stage,
//        i_doa/i_doa_next RAM read data, o_dat/o_last/o_vld result.
module lut_interp_math
  import lut_interp_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic              i_vld,
  input  logic [FW-1:0]     i_frac,
  input  logic              i_last,
  input  logic [DWIDTH-1:0] i_doa,
  input  logic [DWIDTH-1:0] i_doa_next,
  output logic [DWIDTH-1:0] o_dat,
  output logic              o_last,
  output logic              o_vld
);
  logic                     r_v1, r_last1;
  logic [FW-1:0]            r_frac1;
  logic                     r_v2, r_last2;
  logic signed [DWIDTH-1:0] r_a2;
  logic signed [PW-1:0]     r_prod2;
  logic                     r_v3, r_last3;
  logic [DWIDTH-1:0]        r_dat3;

  logic signed [DWIDTH:0]   w_diff;
  logic signed [PW-1:0]     w_prod;
  logic signed [DWIDTH-1:0] w_sum;

  // One extra bit so b - a never wraps.
  assign w_diff = $signed({i_doa_next[DWIDTH-1], i_doa_next}) - $signed({i_doa[DWIDTH-1], i_doa});
  // Both operands widened to PW so the multiply is done at full product width;
  // frac is zero-extended (unsigned).
  assign w_prod = $signed({{(PW-DWIDTH-1){w_diff[DWIDTH]}}, w_diff}) *
                  $signed({{(PW-FW){1'b0}}, r_frac1});
  // Result lies between a and b, so keeping only DWIDTH bits is exact.
  assign w_sum  = r_a2 + DWIDTH'(r_prod2 >>> FW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_frac1 <= '0;
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_a2    <= '0;
      r_prod2 <= '0;
      r_v3    <= 1'b0;
      r_last3 <= 1'b0;
      r_dat3  <= '0;
    end else if (i_en) begin
      r_v1 <= i_vld;
      if (i_vld) begin
        r_frac1 <= i_frac;
        r_last1 <= i_last;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_a2    <= $signed(i_doa);
        r_prod2 <= w_prod;
        r_last2 <= r_last1;
      end
      r_v3 <= r_v2;
      if (r_v2) begin
        r_dat3  <= w_sum;
        r_last3 <= r_last2;
      end
    end
  end

  assign o_dat  = r_dat3;
  assign o_last = r_last3;
  assign o_vld  = r_v3;
endmodule

// File: rtl/lut_interp_ctrl.sv
// Streams index samples through a banked dual-port LUT RAM and emits interpolated values.
// Latency: 3 clocks accept-to-output, 1 sample/clk.
// Backpressure: o_tready low with o_tvalid high freezes the pipe and the RAM read port.
// Ports: clk/reset_n; io_axis sample stream; wr_* host writes to the inactive bank;
//        swap_stb/active_bank/swap_pending bank control; ram_* RAM port A (read) / B (write).
module lut_interp_ctrl
  import lut_interp_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  lut_interp_ctrl_if.slave  io_axis,
  input  logic              wr_stb,
  input  logic [TAW-1:0]    wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              swap_stb,
  output logic              active_bank,
  output logic              swap_pending,
  output logic              ram_ena,
  output logic [AW-1:0]     ram_addra,
  input  logic [DWIDTH-1:0] ram_doa,
  input  logic [DWIDTH-1:0] ram_doa_next,
  output logic              ram_enb,
  output logic              ram_web,
  output logic [AW-1:0]     ram_addrb,
  output logic [DWIDTH-1:0] ram_dib
);
  logic              w_en, w_acc, w_apply;
  logic              w_o_tvalid, w_o_tlast;
  logic [DWIDTH-1:0] w_o_tdata;
  logic              r_in_pkt, r_active_bank;
  swap_state_e       r_state, w_state_nxt;

  assign w_en  = ~w_o_tvalid | io_axis.o_tready;
  assign w_acc = io_axis.i_tvalid & w_en;

  assign io_axis.i_tready = w_en;
  assign ram_ena          = w_en;
  // The bank is fixed into the address at accept, so in-flight samples keep it.
  assign ram_addra        = {r_active_bank, idx_of(io_axis.i_tdata)};

  // Host writes can only ever reach the bank lookups are not using.
  assign ram_enb   = wr_stb;
  assign ram_web   = wr_stb;
  assign ram_addrb = {~r_active_bank, wr_addr};
  assign ram_dib   = wr_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_pkt      <= 1'b0;
      r_state       <= IDLE;
      r_active_bank <= 1'b0;
    end else begin
      if (w_acc) r_in_pkt <= ~io_axis.i_tlast;
      r_state <= w_state_nxt;
      if (w_apply) r_active_bank <= ~r_active_bank;
    end
  end

  // Swap waits for a packet boundary: either a quiet cycle outside a packet,
  // or the edge that accepts the packet's last sample.
  always_comb begin
    w_state_nxt  = r_state;
    w_apply      = 1'b0;
    swap_pending = 1'b0;
    case (r_state)
      IDLE: if (swap_stb) w_state_nxt = PEND;
      PEND: begin
        swap_pending = 1'b1;
        if ((w_acc & io_axis.i_tlast) | (~r_in_pkt & ~w_acc)) begin
          w_apply     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign active_bank = r_active_bank;

  lut_interp_math u_math (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (w_en),
    .i_vld      (io_axis.i_tvalid),
    .i_frac     (frac_of(io_axis.i_tdata)),
    .i_last     (io_axis.i_tlast),
    .i_doa      (ram_doa),
    .i_doa_next (ram_doa_next),
    .o_dat      (w_o_tdata),
    .o_last     (w_o_tlast),
    .o_vld      (w_o_tvalid)
  );

  assign io_axis.o_tdata  = w_o_tdata;
  assign io_axis.o_tlast  = w_o_tlast;
  assign io_axis.o_tvalid = w_o_tvalid;
endmodule

// File: tb/tb_lut_interp_ctrl.sv
// Bench for lut_interp_ctrl: RAM model, behavioural interpolation/bank model, directed + random stimulus.
// Latency: n/a.
// Backpressure: o_tready randomised during the streaming phase.
module tb_lut_interp_ctrl;
  import lut_interp_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lut_interp_ctrl_if io();

  logic              wr_stb = 1'b0;
  logic [TAW-1:0]    wr_addr = '0;
  logic [DWIDTH-1:0] wr_data = '0;
  logic              swap_stb = 1'b0;
  logic              active_bank, swap_pending;
  logic              ram_ena, ram_enb, ram_web;
  logic [AW-1:0]     ram_addra, ram_addrb;
  logic [DWIDTH-1:0] ram_doa, ram_doa_next, ram_dib;

  lut_interp_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io_axis      (io),
    .wr_stb       (wr_stb),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap_stb     (swap_stb),
    .active_bank  (active_bank),
    .swap_pending (swap_pending),
    .ram_ena      (ram_ena),
    .ram_addra    (ram_addra),
    .ram_doa      (ram_doa),
    .ram_doa_next (ram_doa_next),
    .ram_enb      (ram_enb),
    .ram_web      (ram_web),
    .ram_addrb    (ram_addrb),
    .ram_dib      (ram_dib)
  );

  // Dual-port RAM with next-entry read; the top address repeats itself as next.
  logic [DWIDTH-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_enb && ram_web) mem[ram_addrb] <= ram_dib;
    if (ram_ena) begin
      ram_doa      <= mem[ram_addra];
      ram_doa_next <= (ram_addra == '1) ? mem[ram_addra] : mem[ram_addra + 1'b1];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic fail(input string nm, input string msg);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  function automatic int sx(input logic [DWIDTH-1:0] x);
    return int'($signed(x));
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { int v; bit last; } exp_t;
  logic [DWIDTH-1:0] m_tbl [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) m_tbl[i] = '0;
  bit   m_bank, m_pend, m_inpkt;
  exp_t exp_q[$];
  int   out_log[$];
  bit   hold_vld;
  logic [DWIDTH-1:0] hold_dat;
  logic hold_last;
  bit   acc, apply;

  // a + floor((b - a) * frac / 2^FW), read from the given bank.
  function automatic int model_out(input logic [IW-1:0] d, input bit bank);
    logic [AW-1:0]     ia, ib;
    logic [DWIDTH-1:0] t;
    int a, b, p, q;
    ia = {bank, d[IW-1:FW]};
    ib = (ia == '1) ? ia : ia + 1'b1;
    a  = sx(m_tbl[ia]);
    b  = sx(m_tbl[ib]);
    p  = (b - a) * int'(d[FW-1:0]);
    q  = p / (1 << FW);
    if (p < 0 && (p % (1 << FW)) != 0) q = q - 1;
    t  = DWIDTH'(a + q);
    return sx(t);
  endfunction

  // Compare process: negedge sees the values that the next posedge will act on.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_bank = 1'b0; m_pend = 1'b0; m_inpkt = 1'b0; hold_vld = 1'b0;
    end else begin
      chk("active_bank", active_bank, m_bank);
      chk("swap_pending", swap_pending, m_pend);
      chk("i_tready", io.i_tready, !io.o_tvalid || io.o_tready);
      if (io.o_tvalid === 1'b1) begin
        if (hold_vld) begin
          chk("stall_tdata", io.o_tdata, hold_dat);
          chk("stall_tlast", io.o_tlast, hold_last);
        end
        if (exp_q.size() == 0) fail("spurious_output", $sformatf("o_tdata=%0d with nothing expected", sx(io.o_tdata)));
        else begin
          chk("o_tdata", sx(io.o_tdata), exp_q[0].v);
          chk("o_tlast", io.o_tlast, exp_q[0].last);
          if (io.o_tready) begin
            out_log.push_back(sx(io.o_tdata));
            void'(exp_q.pop_front());
            hold_vld = 1'b0;
          end else begin
            hold_vld = 1'b1; hold_dat = io.o_tdata; hold_last = io.o_tlast;
          end
        end
      end else begin
        if (hold_vld) fail("valid_dropped", "o_tvalid fell before the sample was taken");
        hold_vld = 1'b0;
      end
      acc = io.i_tvalid && io.i_tready;
      if (acc) exp_q.push_back('{model_out(io.i_tdata, m_bank), io.i_tlast});
      if (wr_stb) m_tbl[{~m_bank, wr_addr}] = wr_data;
      apply = m_pend && ((acc && io.i_tlast) || (!m_inpkt && !acc));
      if (acc) m_inpkt = !io.i_tlast;
      if (apply) begin m_bank = !m_bank; m_pend = 1'b0; end
      else if (!m_pend && swap_stb) m_pend = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  bit rnd_rdy = 1'b0;
  initial begin
    io.o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      io.o_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int idx, input int fr, input bit last);
    bit done;
    done = 1'b0;
    io.i_tvalid = 1'b1;
    io.i_tdata  = {TAW'(idx), FW'(fr)};
    io.i_tlast  = last;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk); done = io.i_tready;
      @(posedge clk); #1;
    end
    if (!done) fail("accept_timeout", $sformatf("index %0d never accepted", idx));
  endtask

  task automatic idle();
    io.i_tvalid = 1'b0; io.i_tlast = 1'b0;
  endtask

  task automatic hwrite(input int addr, input int data);
    wr_stb = 1'b1; wr_addr = TAW'(addr); wr_data = DWIDTH'(data);
    tick();
    wr_stb = 1'b0;
  endtask

  task automatic swap_idle();
    swap_stb = 1'b1; tick(); swap_stb = 1'b0; tick(); tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (exp_q.size() != 0 || io.o_tvalid); k++) tick();
    if (exp_q.size() != 0 || io.o_tvalid) fail("drain_timeout", $sformatf("%0d samples still owed", exp_q.size()));
  endtask

  int n;
  int idx;

  initial begin
    io.i_tvalid = 1'b0; io.i_tdata = '0; io.i_tlast = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_o_tvalid", io.o_tvalid, 0);
    chk("reset_o_tlast", io.o_tlast, 0);
    chk("reset_o_tdata", io.o_tdata, 0);
    chk("reset_active_bank", active_bank, 0);
    chk("reset_swap_pending", swap_pending, 0);
    chk("reset_i_tready", io.i_tready, 1);
    reset_n = 1'b1;
    tick();

    // Ramp table in bank 1, then swap it in.
    for (int k = 0; k < 512; k++) hwrite(k, 100 * k);
    swap_idle();
    chk("first_swap_bank", active_bank, 1);
    send(5, 64, 1'b1);
    idle();
    n = 1;
    while (!io.o_tvalid && n < 20) begin tick(); n++; end
    chk("latency", n, 3);
    chk("idx5_frac64", sx(io.o_tdata), 550);
    drain();

    // Negative slope in bank 0.
    hwrite(3, 10);
    hwrite(4, -10);
    swap_idle();
    out_log.delete();
    send(3, 127, 1'b1); idle(); drain();
    chk("neg_count", out_log.size(), 1);
    if (out_log.size() > 0) chk("neg_slope", out_log[0], -10);

    // Top-index flat extrapolation in bank 1.
    hwrite(511, 777);
    swap_idle();
    out_log.delete();
    send(511, 100, 1'b1); idle(); drain();
    chk("clamp_count", out_log.size(), 1);
    if (out_log.size() > 0) chk("top_clamp", out_log[0], 777);

    // Random stream with backpressure and inactive-bank writes.
    rnd_rdy = 1'b1;
    out_log.delete();
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) begin idle(); tick(); end
      if ($urandom_range(0, 2) == 0) begin
        wr_stb = 1'b1; wr_addr = TAW'($urandom_range(0, 63)); wr_data = DWIDTH'($urandom);
      end
      idx = ($urandom_range(0, 7) == 0) ? 511 : $urandom_range(0, 63);
      send(idx, $urandom_range(0, 127), (i % 8) == 7);
      wr_stb = 1'b0;
    end
    idle();
    rnd_rdy = 1'b0;
    drain();
    chk("stream_count", out_log.size(), 64);

    // Swap requested mid-packet; a write lands on the swap edge.
    for (int k = 0; k < 16; k++) hwrite(k, -50 * k);
    out_log.delete();
    for (int k = 0; k < 8; k++) begin
      if (k == 3) swap_stb = 1'b1;
      if (k == 7) begin wr_stb = 1'b1; wr_addr = TAW'(5); wr_data = DWIDTH'(1234); end
      send(k, 0, k == 7);
      swap_stb = 1'b0; wr_stb = 1'b0;
      if (k >= 3 && k < 7) begin
        chk("mid_pending", swap_pending, 1);
        chk("mid_bank_hold", active_bank, 1);
      end
    end
    chk("tlast_swap_bank", active_bank, 0);
    chk("tlast_swap_pending", swap_pending, 0);
    send(2, 0, 1'b0);
    send(5, 0, 1'b1);
    idle(); drain();
    chk("mid_count", out_log.size(), 10);
    for (int k = 0; k < 8; k++)
      if (k < out_log.size()) chk($sformatf("old_bank_%0d", k), out_log[k], 100 * k);
    if (out_log.size() >= 10) begin
      chk("new_bank_idx2", out_log[8], -100);
      chk("write_on_swap", out_log[9], 1234);
    end

    // Reset mid-packet with a swap pending.
    swap_idle();
    chk("pre_reset_bank", active_bank, 1);
    out_log.delete();
    swap_stb = 1'b1;
    send(1, 0, 1'b0);
    swap_stb = 1'b0;
    send(2, 0, 1'b0);
    send(3, 0, 1'b0);
    idle();
    chk("pre_reset_pending", swap_pending, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_o_tvalid", io.o_tvalid, 0);
    chk("mid_reset_o_tdata", io.o_tdata, 0);
    chk("mid_reset_bank", active_bank, 0);
    chk("mid_reset_pending", swap_pending, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    send(2, 0, 1'b1); idle(); drain();
    chk("post_reset_count", out_log.size(), 1);
    if (out_log.size() > 0) chk("post_reset_value", out_log[0], -100);

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
